// File: rtl/qmult_pkg.sv
// Shared constants, the sign-magnitude word type and the round-robin search
// used by the qmult_arbiter slice.
package qmult_pkg;

  localparam int QM_Q   = 15;
  localparam int QM_N   = 32;
  localparam int RR_MAX = 16;

  typedef struct packed {
    logic              sign;
    logic [QM_N-2:0]   mag;
  } sm_word_t;

  // First set bit of vld searching upward (mod nr) from ptr+1; -1 if none.
  function automatic int rr_next_idx(input logic [RR_MAX-1:0] vld,
                                     input int nr, input int ptr);
    int idx;
    int res;
    res = -1;
    for (int i = 1; i <= RR_MAX; i++) begin
      idx = (ptr + i) % nr;
      if (i <= nr && res < 0 && vld[idx[3:0]]) res = idx;
    end
    return res;
  endfunction

endpackage

// File: rtl/qmult_pipe.sv
// Two-stage sign-magnitude Q multiplier: S1 issue register, S2 product/overflow
// logic whose result is captured by the caller's output register.
// Build option: define QMULT_ARB_SAT_EN to saturate the magnitude on overflow.
module qmult_pipe
  import qmult_pkg::*;
#(
  parameter int Q   = QM_Q,
  parameter int N   = QM_N,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           in_vld,
  input  logic [N-1:0]   in_a,
  input  logic [N-1:0]   in_b,
  input  logic [IDW-1:0] in_id,
  output logic           out_vld,
  output logic [N-1:0]   out_result,
  output logic           out_ovr,
  output logic [IDW-1:0] out_id
);

  localparam int PQW = 2*N - 2 - Q;

  logic           s1_vld;
  logic [N-1:0]   s1_a, s1_b;
  logic [IDW-1:0] s1_id;
  logic [PQW-1:0] prod_q;
  logic [N-2:0]   mag;
  logic           ovr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_a   <= '0;
      s1_b   <= '0;
      s1_id  <= '0;
    end else if (en) begin
      s1_vld <= in_vld;
      if (in_vld) begin
        s1_a  <= in_a;
        s1_b  <= in_b;
        s1_id <= in_id;
      end
    end
  end

  // Full 2N-2 bit magnitude product, pre-shifted so the Q fraction bits drop off.
  assign prod_q = PQW'(((2*N-2)'(s1_a[N-2:0]) * (2*N-2)'(s1_b[N-2:0])) >> Q);
  assign ovr    = |prod_q[PQW-1:N-1];

  always_comb begin
    mag = prod_q[N-2:0];
`ifdef QMULT_ARB_SAT_EN
    if (ovr) mag = '1;
`endif
  end

  assign out_vld    = s1_vld;
  assign out_result = {s1_a[N-1] ^ s1_b[N-1], mag};
  assign out_ovr    = ovr;
  assign out_id     = s1_id;

endmodule

// File: rtl/qmult_arbiter.sv
// Round-robin front end sharing one qmult_pipe between NR requesters, with a
// stallable output register. Build option: QMULT_ARB_SAT_EN (see qmult_pipe).
module qmult_arbiter
  import qmult_pkg::*;
#(
  parameter int Q   = QM_Q,
  parameter int N   = QM_N,
  parameter int NR  = 4,
  parameter int IDW = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [NR-1:0]   i_req_valid,
  input  logic [NR*N-1:0] i_req_a,
  input  logic [NR*N-1:0] i_req_b,
  output logic [NR-1:0]   o_req_ready,
  output logic            o_rsp_valid,
  output logic [N-1:0]    o_rsp_result,
  output logic            o_rsp_ovr,
  output logic [IDW-1:0]  o_rsp_id,
  input  logic            i_rsp_ready,
  output logic            o_busy
);

  logic                 advance;
  logic                 xfer;
  logic [IDW-1:0]       rr_ptr;
  logic [IDW-1:0]       gnt_idx;
  logic [NR-1:0]        gnt;
  logic [NR-1:0][N-1:0] a_arr, b_arr;
  logic                 p_vld;
  logic [N-1:0]         p_result;
  logic                 p_ovr;
  logic [IDW-1:0]       p_id;

  assign a_arr   = i_req_a;
  assign b_arr   = i_req_b;
  assign advance = !o_rsp_valid || i_rsp_ready;

  always_comb begin
    int gi;
    gi      = rr_next_idx(RR_MAX'(i_req_valid), NR, int'(rr_ptr));
    gnt     = '0;
    gnt_idx = '0;
    if (gi >= 0) begin
      gnt     = NR'(1) << gi;
      gnt_idx = IDW'(gi);
    end
  end

  // Reset gating keeps ready low while the async reset is held.
  assign o_req_ready = (advance && i_rst_n) ? gnt : '0;
  assign xfer        = |o_req_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rr_ptr <= IDW'(NR-1);
    else if (xfer) rr_ptr <= gnt_idx;
  end

  qmult_pipe #(.Q(Q), .N(N), .IDW(IDW)) u_pipe (
    .clk        (i_clk),
    .rst_n      (i_rst_n),
    .en         (advance),
    .in_vld     (xfer),
    .in_a       (a_arr[gnt_idx]),
    .in_b       (b_arr[gnt_idx]),
    .in_id      (gnt_idx),
    .out_vld    (p_vld),
    .out_result (p_result),
    .out_ovr    (p_ovr),
    .out_id     (p_id)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rsp_valid  <= 1'b0;
      o_rsp_result <= '0;
      o_rsp_ovr    <= 1'b0;
      o_rsp_id     <= '0;
    end else if (advance) begin
      o_rsp_valid <= p_vld;
      if (p_vld) begin
        o_rsp_result <= p_result;
        o_rsp_ovr    <= p_ovr;
        o_rsp_id     <= p_id;
      end
    end
  end

  assign o_busy = p_vld | o_rsp_valid;

endmodule

// File: tb/tb_qmult_arbiter.sv
// Randomized scoreboard bench for qmult_arbiter (Q=15, N=32, NR=4).
module tb_qmult_arbiter;
  import qmult_pkg::*;

  localparam int NR = 4;

  logic            i_clk = 1'b0;
  logic            i_rst_n = 1'b0;
  logic [NR-1:0]   i_req_valid = '0;
  logic [NR*32-1:0] i_req_a = '0;
  logic [NR*32-1:0] i_req_b = '0;
  logic [NR-1:0]   o_req_ready;
  logic            o_rsp_valid;
  logic [31:0]     o_rsp_result;
  logic            o_rsp_ovr;
  logic [1:0]      o_rsp_id;
  logic            i_rsp_ready = 1'b1;
  logic            o_busy;

  qmult_arbiter #(.Q(15), .N(32), .NR(NR), .IDW(2)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req_valid(i_req_valid),
    .i_req_a(i_req_a), .i_req_b(i_req_b), .o_req_ready(o_req_ready),
    .o_rsp_valid(o_rsp_valid), .o_rsp_result(o_rsp_result),
    .o_rsp_ovr(o_rsp_ovr), .o_rsp_id(o_rsp_id),
    .i_rsp_ready(i_rsp_ready), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] pend [NR][$];
  logic [34:0] sb [$];
  logic [NR-1:0] xferred = '0;
  int  tb_ptr = NR-1;
  bit  gaps = 0;
  bit  rand_ready = 0;
  bit  stall_prev = 0;
  logic [35:0] prev_out;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference product straight from the sign-magnitude Q arithmetic rules.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b, input int id);
    logic [63:0] p;
    logic [63:0] m;
    logic        ovr;
    sm_word_t    r;
    p   = 64'(a[30:0]) * 64'(b[30:0]);
    m   = (p >> 15) & 64'h7FFF_FFFF;
    ovr = (p >> 46) != 0;
`ifdef QMULT_ARB_SAT_EN
    if (ovr) m = 64'h7FFF_FFFF;
`endif
    r.sign = a[31] ^ b[31];
    r.mag  = m[30:0];
    return {2'(id), ovr, r};
  endfunction

  function automatic logic [NR-1:0] ref_rr(input logic [NR-1:0] v, input int p);
    for (int i = 1; i <= NR; i++) begin
      int k;
      k = (p + i) % NR;
      if (v[k]) return NR'(1) << k;
    end
    return '0;
  endfunction

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(4))
      0: return $urandom;
      1: return {1'($urandom), 31'($urandom) >> (8 + $urandom_range(12))};
      2: return {1'($urandom), 31'd0};
      3: return {1'($urandom), 31'($urandom_range(1 << 17))};
      default: return {1'($urandom), 31'($urandom_range(1 << 16))};
    endcase
  endfunction

  // Monitor: grant order, scoreboard pop, stability under backpressure, reset values.
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      chk("rst_ready", 64'(o_req_ready), 0);
      chk("rst_valid_busy", {62'd0, o_rsp_valid, o_busy}, 0);
      chk("rst_data", {29'd0, o_rsp_id, o_rsp_ovr, o_rsp_result}, 0);
      stall_prev = 0;
    end else begin
      logic [NR-1:0] exp_g;
      exp_g = (!o_rsp_valid || i_rsp_ready) ? ref_rr(i_req_valid, tb_ptr) : '0;
      chk("grant", 64'(o_req_ready), 64'(exp_g));
      for (int k = 0; k < NR; k++) begin
        if (exp_g[k]) begin
          sb.push_back(model(i_req_a[k*32 +: 32], i_req_b[k*32 +: 32], k));
          tb_ptr = k;
        end
        if (o_req_ready[k] && i_req_valid[k]) xferred[k] = 1'b1;
      end
      if (stall_prev)
        chk("stall_hold", 64'({o_rsp_valid, o_rsp_id, o_rsp_ovr, o_rsp_result}), 64'(prev_out));
      if (o_rsp_valid && i_rsp_ready) begin
        if (sb.size() == 0) chk("rsp_unexpected", 64'(sb.size()), 1);
        else chk("rsp", 64'({o_rsp_id, o_rsp_ovr, o_rsp_result}), 64'(sb.pop_front()));
      end
      stall_prev = o_rsp_valid && !i_rsp_ready;
      prev_out   = {o_rsp_valid, o_rsp_id, o_rsp_ovr, o_rsp_result};
    end
  end

  // Requester driver: hold operands until accepted, optionally idle or drop valid.
  always @(posedge i_clk) begin
    #1;
    if (i_rst_n) begin
      for (int k = 0; k < NR; k++) begin
        if (xferred[k]) begin
          void'(pend[k].pop_front());
          xferred[k] = 1'b0;
          i_req_valid[k] = 1'b0;
        end
        if (!i_req_valid[k] && pend[k].size() > 0 && (!gaps || $urandom_range(3) != 0)) begin
          i_req_a[k*32 +: 32] = pend[k][0][63:32];
          i_req_b[k*32 +: 32] = pend[k][0][31:0];
          i_req_valid[k] = 1'b1;
        end else if (i_req_valid[k] && gaps && $urandom_range(7) == 0) begin
          i_req_valid[k] = 1'b0;
        end
      end
      if (rand_ready) i_rsp_ready = ($urandom_range(2) != 0);
    end
  end

  task automatic wait_idle(input int bound);
    int n;
    int left;
    n = 0;
    left = 1;
    while (left != 0 && n < bound) begin
      @(negedge i_clk);
      n++;
      left = sb.size() + int'(o_busy);
      for (int k = 0; k < NR; k++) left += pend[k].size();
    end
    chk("idle_left", 64'(left), 0);
  endtask

  task automatic timed_op(input int k, input logic [31:0] a, input logic [31:0] b);
    int n;
    pend[k].push_back({a, b});
    n = 0;
    do begin @(negedge i_clk); n++; end while (!o_req_ready[k] && n < 50);
    chk("grant_seen", 64'(o_req_ready[k]), 1);
    @(posedge i_clk); @(negedge i_clk);
    chk("lat1_valid", 64'(o_rsp_valid), 0);
    @(posedge i_clk); @(negedge i_clk);
    chk("lat2_valid", 64'(o_rsp_valid), 1);
    wait_idle(50);
  endtask

  initial begin
    i_req_valid = '1;
    repeat (3) @(posedge i_clk);
    #2; i_req_valid = '0; i_rst_n = 1'b1;

    timed_op(0, 32'h0000C000, 32'h00010000);
    timed_op(2, 32'h80008000, 32'h00004000);
    timed_op(1, 32'h01000000, 32'h01000000);
    timed_op(3, 32'h80000000, 32'h00010000);

    // Round robin among 0,1,3 with continuous valid.
    for (int i = 0; i < 3; i++) begin
      pend[0].push_back({rnd_op(), rnd_op()});
      pend[1].push_back({rnd_op(), rnd_op()});
      pend[3].push_back({rnd_op(), rnd_op()});
    end
    wait_idle(100);

    // Backpressure with every requester waiting.
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < NR; k++) pend[k].push_back({rnd_op(), rnd_op()});
    repeat (3) @(posedge i_clk);
    #1; i_rsp_ready = 1'b0;
    repeat (5) @(posedge i_clk);
    #1; i_rsp_ready = 1'b1;
    wait_idle(200);

    // Randomized traffic and consumer stalls.
    gaps = 1; rand_ready = 1;
    for (int i = 0; i < 200; i++) pend[$urandom_range(NR-1)].push_back({rnd_op(), rnd_op()});
    wait_idle(3000);
    gaps = 0; rand_ready = 0; i_rsp_ready = 1'b1;

    // Reset with S1 and the output register occupied.
    for (int i = 0; i < 6; i++)
      for (int k = 0; k < NR; k++) pend[k].push_back({rnd_op(), rnd_op()});
    repeat (4) @(posedge i_clk);
    #3;
    chk("busy_pre_rst", 64'(o_busy), 1);
    i_rst_n = 1'b0;
    #1;
    chk("rst_imm_valid", {61'd0, o_rsp_valid, o_busy, |o_req_ready}, 0);
    chk("rst_imm_data", {29'd0, o_rsp_id, o_rsp_ovr, o_rsp_result}, 0);
    for (int k = 0; k < NR; k++) pend[k].delete();
    i_req_valid = '0; xferred = '0; sb.delete(); tb_ptr = NR-1;
    repeat (2) @(posedge i_clk);
    #2; i_rst_n = 1'b1;
    pend[2].push_back({32'h00008000, 32'h00008000});
    pend[0].push_back({32'h00010000, 32'h80004000});
    begin
      int n;
      n = 0;
      do begin @(negedge i_clk); n++; end while (o_req_ready == '0 && n < 20);
      chk("first_after_rst", 64'(o_req_ready), 64'h1);
    end
    wait_idle(100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/qmult_arbiter.md
Name: qmult_arbiter

Overview:
Shares one pipelined sign-magnitude Q-format multiplier between NR requesters. Per-requester valid/ready handshakes are arbitrated round-robin. Each granted operand pair goes through a two-stage multiply. Results return on one response bus tagged with the requester index, with sign-magnitude result semantics and an overflow flag.

Parameters:
Q, 15, fractional bits of operands and result
N, 32, total word width; bit N-1 is the sign, bits N-2:0 the magnitude
NR, 4, number of requesters (2..16)
IDW, 2, width of requester tag; must satisfy 2**IDW >= NR

Ports:
i_clk  input  1  clock
i_rst_n  input  1  reset
i_req_valid  input  NR  per-requester operand valid
i_req_a  input  NR*N  multiplicands; requester k in bits [k*N +: N]
i_req_b  input  NR*N  multipliers, same packing
o_req_ready  output  NR  one-hot grant/accept
o_rsp_valid  output  1  result valid
o_rsp_result  output  N  product in Q format, sign-magnitude
o_rsp_ovr  output  1  overflow flag for this result
o_rsp_id  output  IDW  index of the requester that owns the result
i_rsp_ready  input  1  consumer accepts result
o_busy  output  1  any pipeline stage occupied

Behaviour:
- One clock, i_clk. Reset i_rst_n is asynchronous and active-low.
- Reset clears all valid bits and sets o_rsp_result=0, o_rsp_ovr=0, o_rsp_id=0. The RR pointer resets to NR-1, so requester 0 has first priority. Outputs during reset: o_req_ready=0, o_rsp_valid=0, o_busy=0.
- Reset mid-operation discards all in-flight operations silently. No response is issued for them.
- advance = !o_rsp_valid | i_rsp_ready. The whole pipe moves only when advance is 1.
- Grant is combinational. o_req_ready[k]=1 only when advance=1 and k is the first valid requester searching upward (mod NR) from pointer+1. At most one bit is set.
- A transfer happens on valid&ready. The pointer then updates to k. With no transfer, the pointer holds.
- Requesters hold valid and operands stable until ready. Dropping valid without a grant is legal.
- Stage S1 (issue reg) captures a, b, and the id.
- Stage S2 computes and registers:
  - p = a[N-2:0]*b[N-2:0], 2N-2 bits unsigned.
  - sign = a[N-1]^b[N-1].
  - mag = p[N-2+Q:Q].
  - ovr = |p[2N-3:N-1+Q].
- The output register presents S2 as {sign,mag}, ovr, id.
- Latency: grant in cycle t gives o_rsp_valid in cycle t+2 when there is no backpressure. Throughput is one result per cycle.
- Backpressure: while o_rsp_valid=1 and i_rsp_ready=0:
  - outputs hold stable;
  - S1 and S2 hold;
  - o_req_ready=0.
- Simultaneous o_rsp_valid&i_rsp_ready and a new grant are legal. There is no bubble.
- A zero magnitude with the sign bit set (negative zero) is passed through unaltered.
- o_busy = OR of the S1, S2 and output valid bits.

Optional Feature:
QMULT_ARB_SAT_EN:
- Defined: when ovr=1, mag is forced to all ones. The result is {sign, {N-1{1'b1}}} and o_rsp_ovr is still 1.
- Undefined: the magnitude is truncated to p[N-2+Q:Q] and ovr only flags the overflow.

Decomposition:
- Package qmult_pkg holds the shared constants and types:
  - default Q and N localparams;
  - the sign-magnitude word typedef;
  - the RR next-grant function.
- The natural sub-module is qmult_pipe. It is the two-stage sign-magnitude multiplier with an enable (advance), and it carries id and valid through alongside the data.
- The arbiter, handshake and output register stay in the top.

Test Plan (Q=15, N=32, NR=4):
- Basic multiply:
  - Req0 sends a=0x0000C000 (1.5), b=0x00010000 (2.0).
  - Expect o_rsp_valid 2 cycles after the grant, with result 0x00018000, ovr=0, id=0.
- Sign:
  - Req2 sends a=0x80008000 (-1.0), b=0x00004000 (0.5).
  - Expect result 0x80004000, ovr=0, id=2.
- Overflow:
  - a=b=0x01000000 (512.0).
  - Without the macro: result 0x00000000, ovr=1.
  - With QMULT_ARB_SAT_EN: result 0x7FFFFFFF, ovr=1.
- Round-robin:
  - Req0, req1 and req3 hold valid continuously, with i_rsp_ready=1.
  - Expect grant sequence 0,1,3,0,1,3 and o_rsp_id following it 2 cycles later.
- Backpressure:
  - Hold i_rsp_ready=0 for 5 cycles with all requesters valid.
  - Expect o_rsp stable and o_req_ready=0 throughout.
  - On release, all pending results drain in order with no loss or duplication.
- Reset mid-op:
  - Assert i_rst_n=0 with S1 and S2 full.
  - Expect all outputs at reset values immediately.
  - After release, no stale response appears and req0 gets first grant.
